// File: rtl/noc_axis_flit_injector.sv
// rtl/noc_axis_flit_injector.sv - AXI-Stream to NoC flit injector with credit flow control
//
// Purpose: holds one AXI-Stream beat, slices it into SERIALIZATION_FACTOR flits
// (LSB slice first) and presents them to the router injection port, spending
// one credit per flit. The credit counter mirrors free slots in the router's
// input flit buffer.
//
// Ports:
//   clk_noc, rst          clock, synchronous active-high reset
//   axis_in_*             AXI-Stream slave (tvalid/tready/tdata/tlast/tid/tdest)
//   data_out, dest_out    flit payload and {tdest, tid} destination
//   is_tail_out, send_out tail marker and flit valid
//   credit_in             one-cycle pulse returning one buffer slot
//   credits_avail         current credit count (debug)
//   pkt_count, stall_count  performance counters, only with NOC_INJ_PERF_CNT_EN
//
// Optional feature macro: NOC_INJ_PERF_CNT_EN

module noc_axis_flit_injector #(
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
  parameter int CREDIT_COUNT         = 8,
  parameter int CW                   = $clog2(CREDIT_COUNT + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic                   axis_in_tlast,
  input  logic [TID_WIDTH-1:0]   axis_in_tid,
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  output logic [CW-1:0]          credits_avail
`ifdef NOC_INJ_PERF_CNT_EN
  ,
  output logic [31:0]            pkt_count,
  output logic [31:0]            stall_count
`endif
);

  localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_COUNT);

  logic                   hold_valid;
  logic [TDATA_WIDTH-1:0] hold_data;
  logic [DEST_WIDTH-1:0]  hold_dest;
  logic                   hold_last;
  logic [IDX_W-1:0]       flit_idx;
  logic [CW-1:0]          credits;

  logic                   fire;
  logic                   at_last_idx;
  logic                   last_fire;
  logic                   accept;
  logic [FLIT_WIDTH-1:0]  flit_slice;
  logic [CW-1:0]          credits_nxt;

  // Everything downstream-facing is derived from registers only, so credit_in
  // never has a combinational path to send_out.
  assign fire        = hold_valid & (credits != '0);
  assign at_last_idx = (flit_idx == LAST_IDX);
  assign last_fire   = fire & at_last_idx;

  // The final flit of a beat frees the hold register in the same cycle, which
  // is what lets back-to-back beats stream without a bubble.
  assign axis_in_tready = ~hold_valid | last_fire;
  assign accept         = axis_in_tvalid & axis_in_tready;

  always_comb begin
    flit_slice = '0;
    for (int i = 0; i < SERIALIZATION_FACTOR; i++) begin
      if (flit_idx == IDX_W'(i)) begin
        flit_slice = hold_data[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  assign send_out      = fire;
  assign data_out      = hold_valid ? flit_slice : '0;
  assign dest_out      = hold_valid ? hold_dest : '0;
  assign is_tail_out   = hold_valid & hold_last & at_last_idx;
  assign credits_avail = credits;

  always_ff @(posedge clk_noc) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_dest  <= '0;
      hold_last  <= 1'b0;
      flit_idx   <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= axis_in_tdata;
      hold_dest  <= {axis_in_tdest, axis_in_tid};
      hold_last  <= axis_in_tlast;
      flit_idx   <= '0;
    end else if (last_fire) begin
      hold_valid <= 1'b0;
      flit_idx   <= '0;
    end else if (fire) begin
      flit_idx   <= flit_idx + IDX_W'(1);
    end
  end

  // A credit returned while already full is a router bug; saturate rather than
  // wrap so the injector cannot overrun the buffer afterwards.
  always_comb begin
    credits_nxt = credits;
    case ({fire, credit_in})
      2'b10:   credits_nxt = credits - CW'(1);
      2'b01:   credits_nxt = (credits == CREDIT_MAX) ? credits : credits + CW'(1);
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst) begin
      credits <= CREDIT_MAX;
    end else begin
      credits <= credits_nxt;
    end
  end

  credit_overflow_a: assert property (@(posedge clk_noc) disable iff (rst)
    !(credit_in && (credits == CREDIT_MAX)));

`ifdef NOC_INJ_PERF_CNT_EN
  always_ff @(posedge clk_noc) begin
    if (rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fire && is_tail_out) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (hold_valid && (credits == '0)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_axis_flit_injector.sv
// tb/tb_noc_axis_flit_injector.sv - directed self-checking bench for noc_axis_flit_injector

module tb_noc_axis_flit_injector;

  logic clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  int checks = 0;
  int errors = 0;

  // Instance A: SERIALIZATION_FACTOR = 1
  logic        a_rst, a_tvalid, a_tready, a_tlast, a_tail, a_send, a_credit;
  logic [31:0] a_tdata, a_data;
  logic [1:0]  a_tid;
  logic [3:0]  a_tdest;
  logic [5:0]  a_dest;
  logic [3:0]  a_cred;

  // Instance B: SERIALIZATION_FACTOR = 4
  logic        b_rst, b_tvalid, b_tready, b_tlast, b_tail, b_send, b_credit;
  logic [31:0] b_tdata;
  logic [7:0]  b_data;
  logic [1:0]  b_tid;
  logic [3:0]  b_tdest;
  logic [5:0]  b_dest;
  logic [3:0]  b_cred;

  noc_axis_flit_injector #(.SERIALIZATION_FACTOR(1)) u_sf1 (
    .clk_noc(clk_noc), .rst(a_rst),
    .axis_in_tvalid(a_tvalid), .axis_in_tready(a_tready), .axis_in_tdata(a_tdata),
    .axis_in_tlast(a_tlast), .axis_in_tid(a_tid), .axis_in_tdest(a_tdest),
    .data_out(a_data), .dest_out(a_dest), .is_tail_out(a_tail), .send_out(a_send),
    .credit_in(a_credit), .credits_avail(a_cred)
  );

  noc_axis_flit_injector #(.SERIALIZATION_FACTOR(4)) u_sf4 (
    .clk_noc(clk_noc), .rst(b_rst),
    .axis_in_tvalid(b_tvalid), .axis_in_tready(b_tready), .axis_in_tdata(b_tdata),
    .axis_in_tlast(b_tlast), .axis_in_tid(b_tid), .axis_in_tdest(b_tdest),
    .data_out(b_data), .dest_out(b_dest), .is_tail_out(b_tail), .send_out(b_send),
    .credit_in(b_credit), .credits_avail(b_cred)
  );

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int sends;
  int beat;
  int steps;
  logic acc;

  initial begin
    a_rst = 1'b1; a_tvalid = 1'b0; a_tdata = '0; a_tlast = 1'b0; a_tid = '0; a_tdest = '0; a_credit = 1'b0;
    b_rst = 1'b1; b_tvalid = 1'b0; b_tdata = '0; b_tlast = 1'b0; b_tid = '0; b_tdest = '0; b_credit = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_send",   a_send,   1'b0);
    chk("rst_tready", a_tready, 1'b1);
    chk("rst_cred",   a_cred,   4'd8);
    chk("rst_data",   a_data,   32'h0);
    chk("rst_dest",   a_dest,   6'h0);
    chk("rst_tail",   a_tail,   1'b0);
    chk("rst_b_cred", b_cred,   4'd8);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_send",   a_send,   1'b0);
      chk("idle_tready", a_tready, 1'b1);
      chk("idle_cred",   a_cred,   4'd8);
    end

    // SF=1 single beat
    a_tvalid = 1'b1; a_tdata = 32'hDEADBEEF; a_tdest = 4'd5; a_tid = 2'd1; a_tlast = 1'b1;
    tick();
    a_tvalid = 1'b0;
    chk("sf1_send", a_send, 1'b1);
    chk("sf1_data", a_data, 32'hDEADBEEF);
    chk("sf1_dest", a_dest, 6'b0101_01);
    chk("sf1_tail", a_tail, 1'b1);
    tick();
    chk("sf1_send_after", a_send, 1'b0);
    chk("sf1_cred_after", a_cred, 4'd7);
    chk("sf1_data_idle",  a_data, 32'h0);
    a_credit = 1'b1;
    tick();
    a_credit = 1'b0;
    chk("sf1_cred_back", a_cred, 4'd8);

    // SF=4 beat sliced LSB first
    b_tvalid = 1'b1; b_tdata = 32'h44332211; b_tdest = 4'd3; b_tid = 2'd2; b_tlast = 1'b1;
    tick();
    b_tvalid = 1'b0;
    chk("sf4_f0_send",  b_send,   1'b1);
    chk("sf4_f0_data",  b_data,   8'h11);
    chk("sf4_f0_tail",  b_tail,   1'b0);
    chk("sf4_f0_rdy",   b_tready, 1'b0);
    chk("sf4_f0_dest",  b_dest,   6'b0011_10);
    tick();
    chk("sf4_f1_data",  b_data,   8'h22);
    chk("sf4_f1_tail",  b_tail,   1'b0);
    chk("sf4_f1_rdy",   b_tready, 1'b0);
    chk("sf4_f1_dest",  b_dest,   6'b0011_10);
    tick();
    chk("sf4_f2_data",  b_data,   8'h33);
    chk("sf4_f2_tail",  b_tail,   1'b0);
    chk("sf4_f2_rdy",   b_tready, 1'b0);
    tick();
    chk("sf4_f3_send",  b_send,   1'b1);
    chk("sf4_f3_data",  b_data,   8'h44);
    chk("sf4_f3_tail",  b_tail,   1'b1);
    chk("sf4_f3_rdy",   b_tready, 1'b1);
    tick();
    chk("sf4_done_send", b_send, 1'b0);
    chk("sf4_done_cred", b_cred, 4'd4);
    b_credit = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    b_credit = 1'b0;
    chk("sf4_cred_back", b_cred, 4'd8);

    // SF=1: 10 back-to-back beats, no credit return -> exactly 8 sends
    sends = 0;
    beat = 0;
    a_tlast = 1'b1; a_tid = 2'd0; a_tdest = 4'd1;
    a_tvalid = 1'b1; a_tdata = 32'd100;
    for (int i = 0; i < 20; i++) begin
      acc = a_tvalid & a_tready;
      tick();
      if (acc) begin
        beat++;
        a_tdata = 32'(100 + beat);
        if (beat == 10) a_tvalid = 1'b0;
      end
      if (a_send) begin
        chk("b2b_data", a_data, 64'(100 + sends));
        sends++;
      end
    end
    chk("b2b_sends",   sends,    8);
    chk("b2b_stall",   a_send,   1'b0);
    chk("b2b_tready",  a_tready, 1'b0);
    chk("b2b_cred0",   a_cred,   4'd0);
    chk("b2b_hold",    a_data,   32'd108);
    a_credit = 1'b1;
    #1;
    chk("b2b_no_comb_path", a_send, 1'b0);
    tick();
    a_credit = 1'b0;
    chk("b2b_credit_send", a_send, 1'b1);
    chk("b2b_credit_data", a_data, 32'd108);
    sends = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_send) sends++;
    end
    chk("b2b_one_only", sends, 0);
    chk("b2b_beat9_held", a_data, 32'd109);
    a_tvalid = 1'b0;

    // SF=1: hold credits at 3 with fire and credit_in every cycle
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_tvalid = 1'b1; a_tdata = 32'h1234_5678;
    steps = 0;
    while (a_cred != 4'd3 && steps < 20) begin
      tick();
      steps++;
    end
    chk("c3_reached", a_cred, 4'd3);
    a_credit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("c3_cred", a_cred, 4'd3);
      chk("c3_send", a_send, 1'b1);
    end
    a_credit = 1'b0;
    a_tvalid = 1'b0;

    // SF=4: reset after the second flit
    b_tvalid = 1'b1; b_tdata = 32'hAABBCCDD; b_tlast = 1'b1;
    tick();
    b_tvalid = 1'b0;
    chk("rm_f0", b_data, 8'hDD);
    tick();
    chk("rm_f1", b_data, 8'hCC);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("rm_send",  b_send,   1'b0);
    chk("rm_cred",  b_cred,   4'd8);
    chk("rm_rdy",   b_tready, 1'b1);
    chk("rm_data",  b_data,   8'h00);
    b_tvalid = 1'b1; b_tdata = 32'h87654321; b_tlast = 1'b0;
    tick();
    b_tvalid = 1'b0;
    chk("rm_new_f0",   b_data, 8'h21);
    chk("rm_new_send", b_send, 1'b1);
    chk("rm_new_cred", b_cred, 4'd8);
    tick();
    chk("rm_new_f1",   b_data, 8'h43);
    chk("rm_new_cred1", b_cred, 4'd7);
    tick();
    tick();
    chk("rm_new_f3",   b_data, 8'h87);
    chk("rm_no_tail",  b_tail, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
